// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared types, field codes, BCD limits and BCD step helpers
//               for the countdown timer engine.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] TGT_MIN  = 2'b00;
    localparam logic [1:0] TGT_SEC  = 2'b01;
    localparam logic [1:0] TGT_MS10 = 2'b10;
    localparam logic [1:0] TGT_NONE = 2'b11;

    localparam logic [7:0] MIN_MAX  = 8'h99;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MS10_MAX = 8'h99;

    // Two-digit BCD increment, wrapping from max back to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement, wrapping from 00 up to max
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Edit-field rotation over min -> sec -> ms_10 -> min
    function automatic logic [1:0] tgt_next(input logic [1:0] t);
        case (t)
            TGT_MIN:  return TGT_SEC;
            TGT_SEC:  return TGT_MS10;
            default:  return TGT_MIN;
        endcase
    endfunction

    function automatic logic [1:0] tgt_prev(input logic [1:0] t);
        case (t)
            TGT_MS10: return TGT_SEC;
            TGT_SEC:  return TGT_MIN;
            default:  return TGT_MS10;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_field.sv
`default_nettype none
// ============================================================================
// Module      : bcd2_field
// Description : Two-digit BCD register with run-time modulus, inc/dec with
//               wrap, parallel load and a combinational borrow-out so that
//               several fields can be chained into one down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2_field
    import countdown_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] max_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] val_o,
    output logic       borrow_o
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    // Next value: load wins; opposing inc/dec cancel each other
    always_comb begin
        val_d = val_q;
        if (load_i)
            val_d = load_val_i;
        else if (inc_i && !dec_i)
            val_d = bcd_inc(val_q, max_i);
        else if (dec_i && !inc_i)
            val_d = bcd_dec(val_q, max_i);
    end

    // A decrement from 00 wraps and asks the next-higher field to borrow
    assign borrow_o = dec_i && !inc_i && !load_i && (val_q == 8'h00);

    // Field register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            val_q <= 8'h00;
        else
            val_q <= val_d;
    end

    assign val_o = val_q;

endmodule
`default_nettype wire

// File: rtl/countdown_core.sv
`default_nettype none
// ============================================================================
// Module      : countdown_core
// Description : Countdown timer engine. Preset is edited field by field in
//               SET, then counted down in steps of one hundredth every
//               TICK_DIV clocks. The displayed value is always the live
//               counter, which tracks preset edits while in SET, so every
//               output comes straight from a register.
//               Optional build macro COUNTDOWN_AUTO_RELOAD_EN: on reaching
//               zero the preset is reloaded and counting continues, with a
//               one-cycle time_out_o pulse instead of entering DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_core
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk_core,
    input  logic       rst_n,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       center_button,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [7:0] ms_10_o,
    output logic       time_out_o,
    output logic [1:0] target
);

    localparam int               c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

    state_t              state_q;
    logic [1:0]          target_q;
    logic [c_TICK_W-1:0] tick_q;
    logic                time_out_q;

    logic [7:0] w_pre_min, w_pre_sec, w_pre_ms;
    logic [7:0] w_live_min, w_live_sec, w_live_ms;
    logic       w_ms_borrow, w_sec_borrow;
    logic       w_pre_min_borrow_unused, w_pre_sec_borrow_unused;
    logic       w_pre_ms_borrow_unused, w_live_min_borrow_unused;

    // ---- button decode with center > left/right > up/down priority ----
    logic w_set, w_start, w_lr_one, w_nav, w_ud_ok, w_inc, w_dec;
    logic w_sel_min, w_sel_sec, w_sel_ms;
    logic w_tick_last, w_step, w_zero_reach, w_reload, w_ack, w_live_load;

    assign w_set     = (state_q == ST_SET);
    assign w_start   = w_set && center_button &&
                       ({w_pre_min, w_pre_sec, w_pre_ms} != 24'h000000);
    assign w_lr_one  = left_button ^ right_button;
    assign w_nav     = w_set && !w_start && w_lr_one;
    assign w_ud_ok   = w_set && !w_start && !w_lr_one;
    assign w_inc     = w_ud_ok && up_button && !down_button;
    assign w_dec     = w_ud_ok && down_button && !up_button;
    assign w_sel_min = (target_q == TGT_MIN);
    assign w_sel_sec = (target_q == TGT_SEC);
    assign w_sel_ms  = (target_q == TGT_MS10);

    assign w_tick_last  = (tick_q == c_TICK_LAST);
    assign w_step       = (state_q == ST_RUN) && !center_button && w_tick_last;
    assign w_zero_reach = w_step && ({w_live_min, w_live_sec, w_live_ms} == 24'h000001);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign w_reload     = w_zero_reach;
`else
    assign w_reload     = 1'b0;
`endif
    assign w_ack        = (state_q == ST_DONE) && center_button;
    assign w_live_load  = w_start || w_ack || w_reload;

    // ---- preset fields ----
    bcd2_field u_pre_min (
        .clk_i(clk_core), .rst_ni(rst_n), .load_i(1'b0), .load_val_i(8'h00),
        .max_i(MIN_MAX), .inc_i(w_inc && w_sel_min), .dec_i(w_dec && w_sel_min),
        .val_o(w_pre_min), .borrow_o(w_pre_min_borrow_unused)
    );
    bcd2_field u_pre_sec (
        .clk_i(clk_core), .rst_ni(rst_n), .load_i(1'b0), .load_val_i(8'h00),
        .max_i(SEC_MAX), .inc_i(w_inc && w_sel_sec), .dec_i(w_dec && w_sel_sec),
        .val_o(w_pre_sec), .borrow_o(w_pre_sec_borrow_unused)
    );
    bcd2_field u_pre_ms (
        .clk_i(clk_core), .rst_ni(rst_n), .load_i(1'b0), .load_val_i(8'h00),
        .max_i(MS10_MAX), .inc_i(w_inc && w_sel_ms), .dec_i(w_dec && w_sel_ms),
        .val_o(w_pre_ms), .borrow_o(w_pre_ms_borrow_unused)
    );

    // ---- live counter: mirrors edits in SET, chained borrow while running ----
    bcd2_field u_live_ms (
        .clk_i(clk_core), .rst_ni(rst_n), .load_i(w_live_load), .load_val_i(w_pre_ms),
        .max_i(MS10_MAX), .inc_i(w_inc && w_sel_ms),
        .dec_i((w_dec && w_sel_ms) || w_step),
        .val_o(w_live_ms), .borrow_o(w_ms_borrow)
    );
    bcd2_field u_live_sec (
        .clk_i(clk_core), .rst_ni(rst_n), .load_i(w_live_load), .load_val_i(w_pre_sec),
        .max_i(SEC_MAX), .inc_i(w_inc && w_sel_sec),
        .dec_i((w_dec && w_sel_sec) || (w_step && w_ms_borrow)),
        .val_o(w_live_sec), .borrow_o(w_sec_borrow)
    );
    bcd2_field u_live_min (
        .clk_i(clk_core), .rst_ni(rst_n), .load_i(w_live_load), .load_val_i(w_pre_min),
        .max_i(MIN_MAX), .inc_i(w_inc && w_sel_min),
        .dec_i((w_dec && w_sel_min) || (w_step && w_sec_borrow)),
        .val_o(w_live_min), .borrow_o(w_live_min_borrow_unused)
    );

    // Mode FSM with tick divider, edit target and time-out flag
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SET;
            target_q   <= TGT_MIN;
            tick_q     <= '0;
            time_out_q <= 1'b0;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            time_out_q <= 1'b0;
`endif
            case (state_q)
                ST_SET: begin
                    if (w_start) begin
                        state_q  <= ST_RUN;
                        target_q <= TGT_NONE;
                        tick_q   <= '0;
                    end else if (w_nav) begin
                        target_q <= right_button ? tgt_next(target_q) : tgt_prev(target_q);
                    end
                end
                ST_RUN: begin
                    if (center_button) begin
                        state_q <= ST_PAUSE;
                    end else if (w_tick_last) begin
                        tick_q <= '0;
                        if (w_zero_reach) begin
                            time_out_q <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
                            state_q    <= ST_DONE;
`endif
                        end
                    end else begin
                        tick_q <= tick_q + c_TICK_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (center_button)
                        state_q <= ST_RUN;
                end
                ST_DONE: begin
                    if (center_button) begin
                        state_q    <= ST_SET;
                        target_q   <= TGT_MIN;
                        time_out_q <= 1'b0;
                    end
                end
                default: state_q <= ST_SET;
            endcase
        end
    end

    assign min_o      = w_live_min;
    assign sec_o      = w_live_sec;
    assign ms_10_o    = w_live_ms;
    assign time_out_o = time_out_q;
    assign target     = target_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_core
// Description : Self-checking bench for countdown_core. Vector rows carry one
//               cycle of buttons and the outputs expected after that edge;
//               expectations are queued at drive time and compared one edge
//               later. Set COUNTDOWN_AUTO_RELOAD_EN to match the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_core;

    localparam int TD = 4;

    localparam logic [4:0] B_0 = 5'b00000;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    typedef struct {
        bit          rst;
        logic [4:0]  btn;
        logic [26:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [26:0] exp;
    } sb_t;

    logic       clk_core = 1'b0;
    logic       rst_n;
    logic       left_button, right_button, up_button, down_button, center_button;
    logic [7:0] min_o, sec_o, ms_10_o;
    logic       time_out_o;
    logic [1:0] target;

    int   n_pass  = 0;
    int   n_total = 0;
    int   row_id  = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    countdown_core #(.TICK_DIV(TD)) dut (
        .clk_core     (clk_core),
        .rst_n        (rst_n),
        .left_button  (left_button),
        .right_button (right_button),
        .up_button    (up_button),
        .down_button  (down_button),
        .center_button(center_button),
        .min_o        (min_o),
        .sec_o        (sec_o),
        .ms_10_o      (ms_10_o),
        .time_out_o   (time_out_o),
        .target       (target)
    );

    always #5 clk_core = ~clk_core;

    function automatic logic [26:0] E(input logic [7:0] m, input logic [7:0] s,
                                      input logic [7:0] ms, input logic to,
                                      input logic [1:0] tg);
        return {m, s, ms, to, tg};
    endfunction

    function automatic logic [7:0] bcd(input int i);
        return {4'(i / 10), 4'(i % 10)};
    endfunction

    function automatic void check(input string name, input logic [26:0] act,
                                  input logic [26:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h:%h.%h to=%b tgt=%b, expected %h:%h.%h to=%b tgt=%b",
                     name, act[26:19], act[18:11], act[10:3], act[2], act[1:0],
                     exp[26:19], exp[18:11], exp[10:3], exp[2], exp[1:0]);
    endfunction

    function automatic void add(input bit r, input logic [4:0] b, input logic [26:0] e);
        vecs.push_back('{r, b, e});
    endfunction

    // One cycle of stimulus; its expected outputs go to the scoreboard
    task automatic drive(input bit r, input logic [4:0] b, input logic [26:0] e);
        @(negedge clk_core);
        if (r) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
        {center_button, left_button, right_button, up_button, down_button} = b;
        sb.push_back('{row_id, e});
        row_id++;
    endtask

    // Scoreboard consumer: compare one edge after the stimulus
    always @(posedge clk_core) begin
        #1;
        if (sb.size() != 0) begin
            sb_t s;
            s = sb.pop_front();
            check($sformatf("row%0d", s.id), {min_o, sec_o, ms_10_o, time_out_o, target}, s.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        {center_button, left_button, right_button, up_button, down_button} = B_0;
        #1 rst_n = 1'b0;
        #2 check("reset_async", {min_o, sec_o, ms_10_o, time_out_o, target}, E(0, 0, 0, 0, 0));
        @(negedge clk_core);
        rst_n = 1'b1;

        // --- A: edit 00:03.99, start, ignored buttons, pause/resume timing ---
        add(1, B_R, E(8'h00, 8'h00, 8'h00, 0, 1));
        add(0, B_U, E(8'h00, 8'h01, 8'h00, 0, 1));
        add(0, B_U, E(8'h00, 8'h02, 8'h00, 0, 1));
        add(0, B_U, E(8'h00, 8'h03, 8'h00, 0, 1));
        add(0, B_R, E(8'h00, 8'h03, 8'h00, 0, 2));
        add(0, B_D, E(8'h00, 8'h03, 8'h99, 0, 2));
        add(0, B_C, E(8'h00, 8'h03, 8'h99, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h99, 0, 3));
        add(0, B_U, E(8'h00, 8'h03, 8'h99, 0, 3));
        add(0, B_L, E(8'h00, 8'h03, 8'h99, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h98, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h98, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h98, 0, 3));
        add(0, B_C, E(8'h00, 8'h03, 8'h98, 0, 3));
        for (int i = 0; i < 10; i++)
            add(0, (i == 3) ? B_D : B_0, E(8'h00, 8'h03, 8'h98, 0, 3));
        add(0, B_C, E(8'h00, 8'h03, 8'h98, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h98, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h97, 0, 3));
        for (int i = 0; i < 3; i++)
            add(0, B_0, E(8'h00, 8'h03, 8'h97, 0, 3));
        add(0, B_0, E(8'h00, 8'h03, 8'h96, 0, 3));

        // --- B: full borrow 01:00.00 -> 00:59.99 ---
        add(1, B_U, E(8'h01, 8'h00, 8'h00, 0, 0));
        add(0, B_C, E(8'h01, 8'h00, 8'h00, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h01, 8'h00, 8'h00, 0, 3));
        add(0, B_0, E(8'h00, 8'h59, 8'h99, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h59, 8'h99, 0, 3));
        add(0, B_0, E(8'h00, 8'h59, 8'h98, 0, 3));

        // --- C: zero reach from 00:00.02 ---
        add(1, B_L, E(8'h00, 8'h00, 8'h00, 0, 2));
        add(0, B_U, E(8'h00, 8'h00, 8'h01, 0, 2));
        add(0, B_U, E(8'h00, 8'h00, 8'h02, 0, 2));
        add(0, B_C, E(8'h00, 8'h00, 8'h02, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h02, 0, 3));
        add(0, B_0, E(8'h00, 8'h00, 8'h01, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h01, 0, 3));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        add(0, B_0, E(8'h00, 8'h00, 8'h02, 1, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h02, 0, 3));
        add(0, B_0, E(8'h00, 8'h00, 8'h01, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h01, 0, 3));
        add(0, B_0, E(8'h00, 8'h00, 8'h02, 1, 3));
        add(0, B_C, E(8'h00, 8'h00, 8'h02, 0, 3));
        for (int i = 0; i < 2 * TD; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h02, 0, 3));
`else
        add(0, B_0, E(8'h00, 8'h00, 8'h00, 1, 3));
        add(0, B_0, E(8'h00, 8'h00, 8'h00, 1, 3));
        add(0, B_U, E(8'h00, 8'h00, 8'h00, 1, 3));
        add(0, B_C, E(8'h00, 8'h00, 8'h02, 0, 0));
        // centre beats up in the same cycle; preset must come back unchanged
        add(0, B_C | B_U, E(8'h00, 8'h00, 8'h02, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h02, 0, 3));
        add(0, B_0, E(8'h00, 8'h00, 8'h01, 0, 3));
        for (int i = 0; i < TD - 1; i++)
            add(0, B_0, E(8'h00, 8'h00, 8'h01, 0, 3));
        add(0, B_0, E(8'h00, 8'h00, 8'h00, 1, 3));
        add(0, B_C, E(8'h00, 8'h00, 8'h02, 0, 0));
`endif

        // --- D: zero-preset start ignored, wraps without carry, priorities ---
        add(1, B_C, E(8'h00, 8'h00, 8'h00, 0, 0));
        add(0, B_U, E(8'h01, 8'h00, 8'h00, 0, 0));
        add(0, B_D, E(8'h00, 8'h00, 8'h00, 0, 0));
        add(0, B_D, E(8'h99, 8'h00, 8'h00, 0, 0));
        add(0, B_U, E(8'h00, 8'h00, 8'h00, 0, 0));
        add(0, B_L, E(8'h00, 8'h00, 8'h00, 0, 2));
        add(0, B_D, E(8'h00, 8'h00, 8'h99, 0, 2));
        add(0, B_L, E(8'h00, 8'h00, 8'h99, 0, 1));
        add(0, B_D, E(8'h00, 8'h59, 8'h99, 0, 1));
        add(0, B_L | B_R, E(8'h00, 8'h59, 8'h99, 0, 1));
        add(0, B_U | B_D, E(8'h00, 8'h59, 8'h99, 0, 1));
        add(0, B_U, E(8'h00, 8'h00, 8'h99, 0, 1));
        add(0, B_R, E(8'h00, 8'h00, 8'h99, 0, 2));
        add(0, B_U, E(8'h00, 8'h00, 8'h00, 0, 2));
        add(0, B_R, E(8'h00, 8'h00, 8'h00, 0, 0));
        add(0, B_R | B_U, E(8'h00, 8'h00, 8'h00, 0, 1));
        add(0, B_R, E(8'h00, 8'h00, 8'h00, 0, 2));
        add(0, B_R, E(8'h00, 8'h00, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].rst, vecs[i].btn, vecs[i].exp);

        // --- E: asynchronous reset in the middle of a run at 00:30.00 ---
        drive(1, B_R, E(8'h00, 8'h00, 8'h00, 0, 1));
        for (int i = 1; i <= 30; i++)
            drive(0, B_U, E(8'h00, bcd(i), 8'h00, 0, 1));
        drive(0, B_C, E(8'h00, 8'h30, 8'h00, 0, 3));
        drive(0, B_0, E(8'h00, 8'h30, 8'h00, 0, 3));
        drive(0, B_0, E(8'h00, 8'h30, 8'h00, 0, 3));
        @(negedge clk_core);
        #2 rst_n = 1'b0;
        #1 check("rst_midrun", {min_o, sec_o, ms_10_o, time_out_o, target}, E(0, 0, 0, 0, 0));
        @(negedge clk_core);
        rst_n = 1'b1;
        drive(0, B_0, E(8'h00, 8'h00, 8'h00, 0, 0));
        drive(0, B_C, E(8'h00, 8'h00, 8'h00, 0, 0));

        @(negedge clk_core);
        {center_button, left_button, right_button, up_button, down_button} = B_0;
        @(negedge clk_core);
        n_total++;
        if (sb.size() == 0)
            n_pass++;
        else
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
